// File: rtl/m_chk.sv
// Self-synchronizing checker for the 4-stage m-sequence a(n+4) = a(n+3) ^ a(n).
// Locks after LOCK_CNT consecutive correct predictions; drops lock after LOSS_ERR errors in a window.
module m_chk #(
  parameter int LOCK_CNT = 8,
  parameter int WIN_LEN  = 16,
  parameter int LOSS_ERR = 3
) (
  input  logic       clk,
  input  logic       res,
  input  logic       din,
  input  logic       din_vld,
  input  logic       clr,
  output logic       lock,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(LOSS_ERR + 1);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
  localparam logic [WW-1:0] WIN_V  = WW'(WIN_LEN);
  localparam logic [EW-1:0] LOSS_V = EW'(LOSS_ERR);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    h;
  logic [1:0]    fill_cnt, fill_cnt_nxt;
  logic [MW-1:0] match_cnt, match_cnt_nxt, match_inc;
  logic [WW-1:0] win_cnt, win_cnt_nxt, win_inc;
  logic [EW-1:0] win_err, win_err_nxt, win_err_inc;
  logic          pred, match;
  logic          lock_nxt, err_nxt;
  logic [7:0]    err_cnt_nxt;

  // An all-zero history can never come from the sequence, so it always counts as a miss.
  assign pred        = h[3] ^ h[0];
  assign match       = (din == pred) && (h != 4'b0000);
  assign match_inc   = match_cnt + 1'b1;
  assign win_inc     = win_cnt + 1'b1;
  assign win_err_inc = match ? win_err : win_err + 1'b1;

  always_ff @(posedge clk) begin
    if (!res) begin
      state     <= FILL;
      h         <= 4'b0000;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      lock      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_cnt_nxt;
      match_cnt <= match_cnt_nxt;
      win_cnt   <= win_cnt_nxt;
      win_err   <= win_err_nxt;
      lock      <= lock_nxt;
      err       <= err_nxt;
      err_cnt   <= err_cnt_nxt;
      if (din_vld) h <= {din, h[3:1]};
    end
  end

  always_comb begin
    state_nxt     = state;
    fill_cnt_nxt  = fill_cnt;
    match_cnt_nxt = match_cnt;
    win_cnt_nxt   = win_cnt;
    win_err_nxt   = win_err;
    if (din_vld) begin
      case (state)
        FILL: begin
          fill_cnt_nxt = fill_cnt + 2'd1;
          if (fill_cnt == 2'd3) begin
            state_nxt     = SEARCH;
            match_cnt_nxt = '0;
          end
        end
        SEARCH: begin
          if (!match) begin
            match_cnt_nxt = '0;
          end else if (match_inc == LOCK_V) begin
            state_nxt     = LOCKED;
            match_cnt_nxt = match_inc;
            win_cnt_nxt   = '0;
            win_err_nxt   = '0;
          end else begin
            match_cnt_nxt = match_inc;
          end
        end
        LOCKED: begin
          // Loss of lock takes precedence over the window wrapping on the same bit.
          if (win_err_inc == LOSS_V) begin
            state_nxt     = SEARCH;
            match_cnt_nxt = '0;
            win_cnt_nxt   = '0;
            win_err_nxt   = '0;
          end else if (win_inc == WIN_V) begin
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else begin
            win_cnt_nxt = win_inc;
            win_err_nxt = win_err_inc;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_comb begin
    lock_nxt = (state_nxt == LOCKED);
    err_nxt  = din_vld && (state == LOCKED) && !match;
    if (clr)
      err_cnt_nxt = 8'd0;
    else if (err_nxt && (err_cnt != 8'hFF))
      err_cnt_nxt = err_cnt + 8'd1;
    else
      err_cnt_nxt = err_cnt;
  end

endmodule
